ps2_vga_sprite_ctrl: RTL and testbench

- Parametrised VGA raster generator with a PS/2 keyboard front end and one movable square sprite.
- Everything runs in the CLK100MHz domain. The pixel rate comes from a clock-enable, not a derived clock.
- Adds PS/2 frame validation, a receive timeout, a prefix-decoding state machine, configurable colour depth and step size, and clamp or wrap-around motion.
- Sits between the board pins and the VGA DAC/connector.

---
 rtl/ps2_vga_sprite_ctrl_if.sv | 25 ++
 rtl/ps2_vga_sprite_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ps2_vga_sprite_ctrl.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_vga_sprite_ctrl_if.sv
// Pin bundle between the sprite controller and the board.
// PS/2 lines come in; VGA colour, sync and key status go out.
interface ps2_vga_sprite_ctrl_if #(
    parameter int COLOR_BITS = 3
);
    logic                  ps2_clk;
    logic                  ps2_data;
    logic [COLOR_BITS-1:0] vga_r;
    logic [COLOR_BITS-1:0] vga_g;
    logic [COLOR_BITS-1:0] vga_b;
    logic                  vga_hs;
    logic                  vga_vs;
    logic [3:0]            key_state;
    logic                  frame_err;

    modport master (
        input  ps2_clk, ps2_data,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, key_state, frame_err
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, key_state, frame_err
    );
endinterface

// File: rtl/ps2_vga_sprite_ctrl.sv
// VGA raster with one movable square sprite steered by PS/2 arrow keys.
// Single clock domain; the pixel rate is a clock-enable derived from CLK100MHz.
module ps2_vga_sprite_ctrl #(
    parameter int CLK_DIV     = 4,
    parameter int COLOR_BITS  = 3,
    parameter int H_PIXELS    = 640,
    parameter int H_FP        = 16,
    parameter int H_PULSE     = 96,
    parameter int H_BP        = 48,
    parameter bit H_POL       = 1'b0,
    parameter int V_PIXELS    = 480,
    parameter int V_FP        = 10,
    parameter int V_PULSE     = 2,
    parameter int V_BP        = 33,
    parameter bit V_POL       = 1'b1,
    parameter int SQ_SIZE     = 10,
    parameter int INIT_X      = 320,
    parameter int INIT_Y      = 240,
    parameter int STEP        = 1,
    parameter int WRAP_MODE   = 0,
    parameter int PS2_TIMEOUT = 20000
) (
    input  logic                  CLK100MHz,
    input  logic                  reset,
    ps2_vga_sprite_ctrl_if.master bus
);

    localparam int H_FRAME = H_PIXELS + H_FP + H_PULSE + H_BP;
    localparam int V_FRAME = V_PIXELS + V_FP + V_PULSE + V_BP;
    localparam int HW      = $clog2(H_FRAME);
    localparam int VW      = $clog2(V_FRAME);
    localparam int DW      = $clog2(CLK_DIV);
    localparam int TW      = $clog2(PS2_TIMEOUT);

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_FRAME - 1);
    localparam logic [HW-1:0] H_VIS      = HW'(H_PIXELS);
    localparam logic [HW-1:0] H_VIS_LAST = HW'(H_PIXELS - 1);
    localparam logic [HW-1:0] H_SYNC_S   = HW'(H_PIXELS + H_FP);
    localparam logic [HW-1:0] H_SYNC_E   = HW'(H_PIXELS + H_FP + H_PULSE - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_FRAME - 1);
    localparam logic [VW-1:0] V_VIS      = VW'(V_PIXELS);
    localparam logic [VW-1:0] V_VIS_LAST = VW'(V_PIXELS - 1);
    localparam logic [VW-1:0] V_SYNC_S   = VW'(V_PIXELS + V_FP);
    localparam logic [VW-1:0] V_SYNC_E   = VW'(V_PIXELS + V_FP + V_PULSE - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(PS2_TIMEOUT - 1);

    // Distances and motion carry an extra sign bit (plus headroom for the step).
    localparam logic signed [HW:0]   SQ_H   = (HW+1)'(SQ_SIZE);
    localparam logic signed [VW:0]   SQ_V   = (VW+1)'(SQ_SIZE);
    localparam logic signed [HW+1:0] X_MIN  = (HW+2)'(SQ_SIZE);
    localparam logic signed [HW+1:0] X_MAX  = (HW+2)'(H_PIXELS - 1 - SQ_SIZE);
    localparam logic signed [HW+1:0] STEP_X = (HW+2)'(STEP);
    localparam logic signed [VW+1:0] Y_MIN  = (VW+2)'(SQ_SIZE);
    localparam logic signed [VW+1:0] Y_MAX  = (VW+2)'(V_PIXELS - 1 - SQ_SIZE);
    localparam logic signed [VW+1:0] STEP_Y = (VW+2)'(STEP);

    typedef enum logic [1:0] {StIdle, StExt, StExtBrk, StBrk} state_e;

    logic [DW-1:0]         r_div;
    logic                  w_pix_ce;
    logic [HW-1:0]         r_h_cnt;
    logic [VW-1:0]         r_v_cnt;
    logic [HW-1:0]         r_pos_x, w_pos_x_d;
    logic [VW-1:0]         r_pos_y, w_pos_y_d;
    logic signed [HW:0]    w_dx;
    logic signed [VW:0]    w_dy;
    logic signed [HW+1:0]  w_nx;
    logic signed [VW+1:0]  w_ny;
    logic                  w_visible, w_border, w_in_sq, w_hs_act, w_vs_act;
    logic [COLOR_BITS-1:0] r_r, r_g, r_b;
    logic                  r_hs, r_vs;

    logic [1:0]            r_c_sync, r_d_sync;
    logic                  r_c_prev;
    logic                  w_fall;
    logic [9:0]            r_shift;
    logic [10:0]           w_frame;
    logic                  w_frame_ok;
    logic [3:0]            r_bit_cnt;
    logic [TW-1:0]         r_to_cnt;
    logic                  r_rx_vld, r_frame_err;
    logic [7:0]            r_rx_byte;

    state_e                r_state, w_state_d;
    logic [3:0]            r_keys, w_keys_d, w_arrow;

    // Pixel clock-enable and raster counters
    assign w_pix_ce = (r_div == DIV_LAST);

    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            r_div   <= '0;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_div <= w_pix_ce ? '0 : r_div + 1'b1;
            if (w_pix_ce) begin
                if (r_h_cnt == H_LAST) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end
            end
        end
    end

    assign w_visible = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign w_border  = (r_h_cnt == '0) || (r_h_cnt == H_VIS_LAST) ||
                       (r_v_cnt == '0) || (r_v_cnt == V_VIS_LAST);
    assign w_dx      = $signed({1'b0, r_h_cnt}) - $signed({1'b0, r_pos_x});
    assign w_dy      = $signed({1'b0, r_v_cnt}) - $signed({1'b0, r_pos_y});
    assign w_in_sq   = (w_dx < SQ_H) && (w_dx > -SQ_H) && (w_dy < SQ_V) && (w_dy > -SQ_V);
    assign w_hs_act  = (r_h_cnt >= H_SYNC_S) && (r_h_cnt <= H_SYNC_E);
    assign w_vs_act  = (r_v_cnt >= V_SYNC_S) && (r_v_cnt <= V_SYNC_E);

    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            r_r  <= '0;
            r_g  <= '0;
            r_b  <= '0;
            r_hs <= ~H_POL;
            r_vs <= ~V_POL;
        end else if (w_pix_ce) begin
            r_hs <= w_hs_act ? H_POL : ~H_POL;
            r_vs <= w_vs_act ? V_POL : ~V_POL;
            r_r  <= (w_visible && w_border) ? '1 : '0;
            r_g  <= '0;
            r_b  <= (w_visible && !w_border && w_in_sq) ? '1 : '0;
        end
    end

    // Sprite motion, evaluated once per frame on the first blanking line
    always_comb begin
        w_nx = $signed({2'b00, r_pos_x});
        if (r_keys[0]) w_nx = w_nx + STEP_X;
        if (r_keys[1]) w_nx = w_nx - STEP_X;
        if (w_nx > X_MAX)      w_pos_x_d = (WRAP_MODE != 0) ? X_MIN[HW-1:0] : X_MAX[HW-1:0];
        else if (w_nx < X_MIN) w_pos_x_d = (WRAP_MODE != 0) ? X_MAX[HW-1:0] : X_MIN[HW-1:0];
        else                   w_pos_x_d = w_nx[HW-1:0];

        w_ny = $signed({2'b00, r_pos_y});
        if (r_keys[2]) w_ny = w_ny + STEP_Y;
        if (r_keys[3]) w_ny = w_ny - STEP_Y;
        if (w_ny > Y_MAX)      w_pos_y_d = (WRAP_MODE != 0) ? Y_MIN[VW-1:0] : Y_MAX[VW-1:0];
        else if (w_ny < Y_MIN) w_pos_y_d = (WRAP_MODE != 0) ? Y_MAX[VW-1:0] : Y_MIN[VW-1:0];
        else                   w_pos_y_d = w_ny[VW-1:0];
    end

    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            r_pos_x <= HW'(INIT_X);
            r_pos_y <= VW'(INIT_Y);
        end else if (w_pix_ce && (r_h_cnt == '0) && (r_v_cnt == V_VIS)) begin
            r_pos_x <= w_pos_x_d;
            r_pos_y <= w_pos_y_d;
        end
    end

    // PS/2 receiver: synchronise, sample data on falling clock edges
    assign w_fall     = r_c_prev & ~r_c_sync[1];
    assign w_frame    = {r_d_sync[1], r_shift};
    assign w_frame_ok = ~w_frame[0] & (^w_frame[9:1]) & w_frame[10];

    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            r_c_sync    <= 2'b11;
            r_d_sync    <= 2'b11;
            r_c_prev    <= 1'b1;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_to_cnt    <= '0;
            r_rx_vld    <= 1'b0;
            r_rx_byte   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_c_sync    <= {r_c_sync[0], bus.ps2_clk};
            r_d_sync    <= {r_d_sync[0], bus.ps2_data};
            r_c_prev    <= r_c_sync[1];
            r_rx_vld    <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt   <= '0;
                    r_rx_vld    <= w_frame_ok;
                    r_rx_byte   <= w_frame[8:1];
                    r_frame_err <= ~w_frame_ok;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    r_shift   <= {r_d_sync[1], r_shift[9:1]};
                end
            end else if (r_bit_cnt != '0) begin
                // A stalled partial frame is dropped without flagging an error
                if (r_to_cnt == TO_LAST) begin
                    r_bit_cnt <= '0;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // Scan-code decoder
    always_comb begin
        case (r_rx_byte)
            8'h75:   w_arrow = 4'b1000;
            8'h72:   w_arrow = 4'b0100;
            8'h6B:   w_arrow = 4'b0010;
            8'h74:   w_arrow = 4'b0001;
            default: w_arrow = 4'b0000;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_keys_d  = r_keys;
        if (r_rx_vld) begin
            unique case (r_state)
                StIdle: begin
                    if (r_rx_byte == 8'hE0)      w_state_d = StExt;
                    else if (r_rx_byte == 8'hF0) w_state_d = StBrk;
                end
                StExt: begin
                    if (r_rx_byte == 8'hF0) begin
                        w_state_d = StExtBrk;
                    end else begin
                        w_state_d = StIdle;
                        w_keys_d  = r_keys | w_arrow;
                    end
                end
                StExtBrk: begin
                    w_state_d = StIdle;
                    w_keys_d  = r_keys & ~w_arrow;
                end
                StBrk: w_state_d = StIdle;
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            r_state <= StIdle;
            r_keys  <= '0;
        end else begin
            r_state <= w_state_d;
            r_keys  <= w_keys_d;
        end
    end

    assign bus.vga_r     = r_r;
    assign bus.vga_g     = r_g;
    assign bus.vga_b     = r_b;
    assign bus.vga_hs    = r_hs;
    assign bus.vga_vs    = r_vs;
    assign bus.key_state = r_keys;
    assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_vga_sprite_ctrl.sv
// Bench for ps2_vga_sprite_ctrl on a shrunken raster; clamp and wrap instances
// share the PS/2 stimulus and reset.
module tb_ps2_vga_sprite_ctrl;

    localparam int CLK_DIV = 2;
    localparam int CB      = 3;
    localparam int HP = 32, HFP = 2, HPU = 4, HBP = 2;
    localparam int VP = 24, VFP = 2, VPU = 2, VBP = 2;
    localparam bit HPOL = 1'b0, VPOL = 1'b1;
    localparam int SQ = 3, IX = 6, IY = 12, STEP = 1, TO = 100;
    localparam int H_FRAME   = HP + HFP + HPU + HBP;
    localparam int V_FRAME   = VP + VFP + VPU + VBP;
    localparam int FRAME_CLK = H_FRAME * V_FRAME * CLK_DIV;

    typedef struct {
        logic [3*CB+1:0] px;
        int              h;
        int              v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r_ps2_clk = 1'b1;
    logic r_ps2_data = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    ps2_vga_sprite_ctrl_if #(.COLOR_BITS(CB)) bus_c ();
    ps2_vga_sprite_ctrl_if #(.COLOR_BITS(CB)) bus_w ();

    assign bus_c.ps2_clk  = r_ps2_clk;
    assign bus_c.ps2_data = r_ps2_data;
    assign bus_w.ps2_clk  = r_ps2_clk;
    assign bus_w.ps2_data = r_ps2_data;

    ps2_vga_sprite_ctrl #(
        .CLK_DIV(CLK_DIV), .COLOR_BITS(CB),
        .H_PIXELS(HP), .H_FP(HFP), .H_PULSE(HPU), .H_BP(HBP), .H_POL(HPOL),
        .V_PIXELS(VP), .V_FP(VFP), .V_PULSE(VPU), .V_BP(VBP), .V_POL(VPOL),
        .SQ_SIZE(SQ), .INIT_X(IX), .INIT_Y(IY), .STEP(STEP), .WRAP_MODE(0),
        .PS2_TIMEOUT(TO)
    ) dut_c (
        .CLK100MHz(clk),
        .reset(rst),
        .bus(bus_c)
    );

    ps2_vga_sprite_ctrl #(
        .CLK_DIV(CLK_DIV), .COLOR_BITS(CB),
        .H_PIXELS(HP), .H_FP(HFP), .H_PULSE(HPU), .H_BP(HBP), .H_POL(HPOL),
        .V_PIXELS(VP), .V_FP(VFP), .V_PULSE(VPU), .V_BP(VBP), .V_POL(VPOL),
        .SQ_SIZE(SQ), .INIT_X(IX), .INIT_Y(IY), .STEP(STEP), .WRAP_MODE(1),
        .PS2_TIMEOUT(TO)
    ) dut_w (
        .CLK100MHz(clk),
        .reset(rst),
        .bus(bus_w)
    );

    // Counts clock cycles with frame_err high on the clamp instance
    always @(posedge clk) begin
        if (bus_c.frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic logic [3*CB+1:0] model_pix(input int h, input int v);
        logic [CB-1:0] r, g, b;
        logic          hs, vs;
        r  = '0;
        g  = '0;
        b  = '0;
        hs = (h >= HP + HFP && h < HP + HFP + HPU) ? HPOL : !HPOL;
        vs = (v >= VP + VFP && v < VP + VFP + VPU) ? VPOL : !VPOL;
        if (h < HP && v < VP) begin
            if (h == 0 || h == HP - 1 || v == 0 || v == VP - 1) r = '1;
            else if (iabs(h - IX) < SQ && iabs(v - IY) < SQ) b = '1;
        end
        return {r, g, b, hs, vs};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            r_ps2_data = bits[i];
            repeat (5) tick();
            r_ps2_clk = 1'b0;
            repeat (10) tick();
            r_ps2_clk = 1'b1;
            repeat (5) tick();
        end
        r_ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        send_bits(f, 11);
        repeat (20) tick();
    endtask

    task automatic wait_vs(output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = bus_c.vga_vs;
        for (int i = 0; i < 3 * FRAME_CLK; i++) begin
            tick();
            if (prev !== VPOL && bus_c.vga_vs === VPOL) begin
                ok = 1'b1;
                break;
            end
            prev = bus_c.vga_vs;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_checks++;
        if ({bus_c.vga_r, bus_c.vga_g, bus_c.vga_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_rgb: got %h want 0", {bus_c.vga_r, bus_c.vga_g, bus_c.vga_b});
        end
        n_checks++;
        if (bus_c.vga_hs !== !HPOL || bus_c.vga_vs !== !VPOL) begin
            n_fail++;
            $display("FAIL reset_sync: got hs=%b vs=%b want hs=%b vs=%b",
                     bus_c.vga_hs, bus_c.vga_vs, !HPOL, !VPOL);
        end
        n_checks++;
        if (bus_c.key_state !== 4'b0000 || bus_c.frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_keys: got keys=%b err=%b want 0000/0",
                     bus_c.key_state, bus_c.frame_err);
        end
        n_checks++;
        if (int'(dut_c.r_pos_x) != IX || int'(dut_c.r_pos_y) != IY) begin
            n_fail++;
            $display("FAIL reset_pos: got (%0d,%0d) want (%0d,%0d)",
                     dut_c.r_pos_x, dut_c.r_pos_y, IX, IY);
        end
    endtask

    task automatic test_raster();
        exp_t q[$];
        exp_t e;
        logic [3*CB+1:0] got;
        int m_div = 0, m_h = 0, m_v = 0;
        int hs_run = 0, vs_run = 0, vs_rises = 0, last_rise = 0;
        logic prev_vs;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        prev_vs = bus_c.vga_vs;
        for (int c = 0; c < 2 * FRAME_CLK + 100; c++) begin
            @(posedge clk);
            if (m_div == CLK_DIV - 1) begin
                e.px = model_pix(m_h, m_v);
                e.h  = m_h;
                e.v  = m_v;
                q.push_back(e);
                m_div = 0;
                if (m_h == H_FRAME - 1) begin
                    m_h = 0;
                    m_v = (m_v == V_FRAME - 1) ? 0 : m_v + 1;
                end else begin
                    m_h++;
                end
            end else begin
                m_div++;
            end
            #1;
            if (q.size() != 0) begin
                e   = q.pop_front();
                got = {bus_c.vga_r, bus_c.vga_g, bus_c.vga_b, bus_c.vga_hs, bus_c.vga_vs};
                n_checks++;
                if (got !== e.px) begin
                    n_fail++;
                    $display("FAIL pixel(%0d,%0d): got rgbhv=%b want %b", e.h, e.v, got, e.px);
                end
            end
            if (bus_c.vga_hs === HPOL) begin
                hs_run++;
            end else begin
                if (hs_run != 0) begin
                    n_checks++;
                    if (hs_run != HPU * CLK_DIV) begin
                        n_fail++;
                        $display("FAIL hs_width: got %0d clocks want %0d", hs_run, HPU * CLK_DIV);
                    end
                end
                hs_run = 0;
            end
            if (bus_c.vga_vs === VPOL) begin
                vs_run++;
                if (prev_vs !== VPOL) begin
                    vs_rises++;
                    if (vs_rises == 2) begin
                        n_checks++;
                        if (c - last_rise != FRAME_CLK) begin
                            n_fail++;
                            $display("FAIL frame_period: got %0d clocks want %0d",
                                     c - last_rise, FRAME_CLK);
                        end
                    end
                    last_rise = c;
                end
            end else begin
                if (vs_run != 0) begin
                    n_checks++;
                    if (vs_run != VPU * H_FRAME * CLK_DIV) begin
                        n_fail++;
                        $display("FAIL vs_width: got %0d clocks want %0d",
                                 vs_run, VPU * H_FRAME * CLK_DIV);
                    end
                end
                vs_run = 0;
            end
            prev_vs = bus_c.vga_vs;
        end
        n_checks++;
        if (vs_rises != 2) begin
            n_fail++;
            $display("FAIL vs_count: got %0d vsync pulses want 2", vs_rises);
        end
    endtask

    task automatic test_key_up();
        int exp_y[$];
        int ey;
        bit ok;
        do_reset();
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        exp_y.push_back(IY - 1);
        exp_y.push_back(IY - 2);
        exp_y.push_back(IY - 3);
        n_checks++;
        if (bus_c.key_state !== 4'b1000) begin
            n_fail++;
            $display("FAIL up_press: got keys=%b want 1000", bus_c.key_state);
        end
        for (int f = 0; f < 3; f++) begin
            wait_vs(ok);
            ey = exp_y.pop_front();
            n_checks++;
            if (!ok || int'(dut_c.r_pos_y) != ey || int'(dut_c.r_pos_x) != IX) begin
                n_fail++;
                $display("FAIL up_move%0d: got (%0d,%0d) vs_ok=%b want (%0d,%0d)",
                         f, dut_c.r_pos_x, dut_c.r_pos_y, ok, IX, ey);
            end
        end
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        n_checks++;
        if (bus_c.key_state !== 4'b0000) begin
            n_fail++;
            $display("FAIL up_release: got keys=%b want 0000", bus_c.key_state);
        end
        for (int f = 0; f < 2; f++) begin
            wait_vs(ok);
            n_checks++;
            if (!ok || int'(dut_c.r_pos_y) != IY - 3) begin
                n_fail++;
                $display("FAIL up_hold%0d: got y=%0d vs_ok=%b want %0d",
                         f, dut_c.r_pos_y, ok, IY - 3);
            end
        end
    endtask

    task automatic test_bad_parity();
        int e0;
        do_reset();
        send_byte(8'hE0, 1'b0);
        e0 = err_cnt;
        send_byte(8'h75, 1'b1);
        n_checks++;
        if (err_cnt - e0 != 1) begin
            n_fail++;
            $display("FAIL parity_err: got %0d frame_err cycles want 1", err_cnt - e0);
        end
        n_checks++;
        if (bus_c.key_state !== 4'b0000) begin
            n_fail++;
            $display("FAIL parity_keys: got keys=%b want 0000", bus_c.key_state);
        end
    endtask

    task automatic test_edge_motion();
        int exp_c[$];
        int exp_w[$];
        int ec, ew;
        bit ok;
        do_reset();
        send_byte(8'hE0, 1'b0);
        send_byte(8'h6B, 1'b0);
        exp_c = '{IX - 1, IX - 2, IX - 3, SQ, SQ};
        exp_w = '{IX - 1, IX - 2, IX - 3, HP - 1 - SQ, HP - 2 - SQ};
        for (int f = 0; f < 5; f++) begin
            wait_vs(ok);
            ec = exp_c.pop_front();
            ew = exp_w.pop_front();
            n_checks++;
            if (!ok || int'(dut_c.r_pos_x) != ec) begin
                n_fail++;
                $display("FAIL clamp_x%0d: got %0d vs_ok=%b want %0d", f, dut_c.r_pos_x, ok, ec);
            end
            n_checks++;
            if (int'(dut_w.r_pos_x) != ew) begin
                n_fail++;
                $display("FAIL wrap_x%0d: got %0d want %0d", f, dut_w.r_pos_x, ew);
            end
        end
    endtask

    task automatic test_timeout();
        int e0;
        logic [10:0] junk;
        do_reset();
        junk = 11'b111_0101_0100;
        e0 = err_cnt;
        send_bits(junk, 6);
        repeat (TO + 10) tick();
        send_byte(8'hE0, 1'b0);
        send_byte(8'h74, 1'b0);
        n_checks++;
        if (err_cnt != e0) begin
            n_fail++;
            $display("FAIL timeout_err: got %0d frame_err cycles want 0", err_cnt - e0);
        end
        n_checks++;
        if (bus_c.key_state !== 4'b0001) begin
            n_fail++;
            $display("FAIL timeout_keys: got keys=%b want 0001", bus_c.key_state);
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        bit ok;
        logic [10:0] junk;
        wait_vs(ok);
        n_checks++;
        if (!ok || int'(dut_c.r_pos_x) != IX + 1) begin
            n_fail++;
            $display("FAIL right_move: got x=%0d vs_ok=%b want %0d", dut_c.r_pos_x, ok, IX + 1);
        end
        junk = 11'b101_1010_1010;
        send_bits(junk, 5);
        repeat (37) tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_checks++;
        if ({bus_c.vga_r, bus_c.vga_g, bus_c.vga_b} !== '0 || bus_c.vga_hs !== !HPOL ||
            bus_c.vga_vs !== !VPOL || bus_c.key_state !== 4'b0000 || bus_c.frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_out: got rgb=%h hs=%b vs=%b keys=%b err=%b want 0/%b/%b/0000/0",
                     {bus_c.vga_r, bus_c.vga_g, bus_c.vga_b}, bus_c.vga_hs, bus_c.vga_vs,
                     bus_c.key_state, bus_c.frame_err, !HPOL, !VPOL);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_checks++;
        if (int'(dut_c.r_pos_x) != IX || int'(dut_c.r_pos_y) != IY || bus_c.key_state !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_pos: got (%0d,%0d) keys=%b want (%0d,%0d) 0000",
                     dut_c.r_pos_x, dut_c.r_pos_y, bus_c.key_state, IX, IY);
        end
        e0 = err_cnt;
        send_byte(8'hE0, 1'b0);
        send_byte(8'h74, 1'b0);
        n_checks++;
        if (bus_c.key_state !== 4'b0001 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL midreset_rx: got keys=%b errs=%0d want 0001 0",
                     bus_c.key_state, err_cnt - e0);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_raster();
        test_key_up();
        test_bad_parity();
        test_edge_motion();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
